// File: rtl/ip_tx_scheduler.sv
// ip_tx_scheduler: two-requester round-robin front end for the IP packet
// transmitter. It captures the winning request, launches one transaction,
// holds the transmitter inputs until the final MAC beat, and aborts a stalled
// transaction with a watchdog.
module ip_tx_scheduler #(
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int ACCEL_DATA_WIDTH = 10,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [1:0]                  REQ_VALID,
  input  logic [IP_ADDR_WIDTH-1:0]    REQ0_IP_ADDRESS,
  input  logic [IP_ADDR_WIDTH-1:0]    REQ1_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]   REQ0_MAC_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]   REQ1_MAC_ADDRESS,
  input  logic [ACCEL_DATA_WIDTH-1:0] REQ0_MESSAGE,
  input  logic [ACCEL_DATA_WIDTH-1:0] REQ1_MESSAGE,
  output logic [1:0]                  REQ_ACCEPT,
  output logic [IP_ADDR_WIDTH-1:0]    RECIPIENT_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]   RECIPIENT_MAC_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0] RECIPIENT_MESSAGE,
  output logic                        START_IP_TXN,
  input  logic                        READY_FOR_SEND,
  input  logic                        MAC_DATA_VALID,
  input  logic                        MAC_DATA_READY,
  input  logic                        MAC_DATA_LAST,
  output logic                        GRANT_ID,
  output logic                        TX_BUSY,
  output logic                        TX_DONE,
  output logic                        TX_ERROR,
  output logic [15:0]                 TX_COUNT0,
  output logic [15:0]                 TX_COUNT1
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_LAST
  } state_t;

  // Watchdog value seen in the last cycle a transaction may still complete.
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t                      state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic                        grant_q, grant_d;
  logic                        winner;
  logic                        capture;
  logic                        complete;
  logic [15:0]                 wd_q, wd_d;
  logic [1:0]                  accept_q, accept_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        start_q, busy_q;
  logic [IP_ADDR_WIDTH-1:0]    ip_q;
  logic [MAC_ADDR_WIDTH-1:0]   mac_q;
  logic [ACCEL_DATA_WIDTH-1:0] msg_q;
  logic [15:0]                 cnt0_q, cnt1_q;

  // A lone request wins outright; on a tie the requester not served last wins.
  assign winner   = (REQ_VALID == 2'b11) ? ~last_grant_q : REQ_VALID[1];
  assign complete = MAC_DATA_VALID & MAC_DATA_READY & MAC_DATA_LAST;

  // State register.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation order between blocks cannot matter.
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, arbitration and pulse decode.
  always_comb begin
    // NOTE: every variable gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wd_d         = wd_q;
    accept_d     = 2'b00;
    done_d       = 1'b0;
    err_d        = 1'b0;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|REQ_VALID) begin
          capture      = 1'b1;
          grant_d      = winner;
          last_grant_d = winner;
          accept_d     = winner ? 2'b10 : 2'b01;
          wd_d         = '0;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_d = wd_q + 16'd1;
        if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (READY_FOR_SEND) begin
          state_d = ST_WAIT_LAST;
        end
      end
      ST_WAIT_LAST: begin
        wd_d = wd_q + 16'd1;
        // A final beat in the abort cycle still counts as a completion.
        if (complete) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, captured request fields, watchdog and counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wd_q         <= '0;
      accept_q     <= 2'b00;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      ip_q         <= '0;
      mac_q        <= '0;
      msg_q        <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wd_q         <= wd_d;
      accept_q     <= accept_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_q      <= (state_d == ST_LAUNCH);
      busy_q       <= (state_d != ST_IDLE);
      if (capture) begin
        ip_q  <= winner ? REQ1_IP_ADDRESS  : REQ0_IP_ADDRESS;
        mac_q <= winner ? REQ1_MAC_ADDRESS : REQ0_MAC_ADDRESS;
        msg_q <= winner ? REQ1_MESSAGE     : REQ0_MESSAGE;
      end
      if (done_d) begin
        if (grant_q) cnt1_q <= cnt1_q + 16'd1;
        else         cnt0_q <= cnt0_q + 16'd1;
      end
    end
  end

  assign REQ_ACCEPT            = accept_q;
  assign RECIPIENT_IP_ADDRESS  = ip_q;
  assign RECIPIENT_MAC_ADDRESS = mac_q;
  assign RECIPIENT_MESSAGE     = msg_q;
  assign START_IP_TXN          = start_q;
  assign GRANT_ID              = grant_q;
  assign TX_BUSY               = busy_q;
  assign TX_DONE               = done_q;
  assign TX_ERROR              = err_q;
  assign TX_COUNT0             = cnt0_q;
  assign TX_COUNT1             = cnt1_q;

endmodule

// File: tb/tb_ip_tx_scheduler.sv
// Self-checking bench for ip_tx_scheduler: randomized fields and handshake
// delays checked against a transaction-level model of arbitration, capture,
// launch, completion, watchdog and counters.
module tb_ip_tx_scheduler;

  localparam int WD_T = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  req_valid;
  logic [31:0] req_ip  [2];
  logic [47:0] req_mac [2];
  logic [9:0]  req_msg [2];
  logic        ready_for_send, mac_valid, mac_ready, mac_last;

  logic [1:0]  accept, wd_accept;
  logic [31:0] rip, wd_rip;
  logic [47:0] rmac, wd_rmac;
  logic [9:0]  rmsg, wd_rmsg;
  logic        start, grant, busy, done, err;
  logic        wd_start, wd_grant, wd_busy, wd_done, wd_err;
  logic [15:0] cnt0, cnt1, wd_cnt0, wd_cnt1;

  // Reference model state.
  int          exp_last;
  logic        exp_grant;
  logic [31:0] exp_ip;
  logic [47:0] exp_mac;
  logic [9:0]  exp_msg;
  logic [15:0] exp_cnt [2];
  logic [15:0] wd_exp_cnt0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  ip_tx_scheduler dut (
    .aclk(aclk), .areset(areset), .REQ_VALID(req_valid),
    .REQ0_IP_ADDRESS(req_ip[0]), .REQ1_IP_ADDRESS(req_ip[1]),
    .REQ0_MAC_ADDRESS(req_mac[0]), .REQ1_MAC_ADDRESS(req_mac[1]),
    .REQ0_MESSAGE(req_msg[0]), .REQ1_MESSAGE(req_msg[1]),
    .REQ_ACCEPT(accept), .RECIPIENT_IP_ADDRESS(rip),
    .RECIPIENT_MAC_ADDRESS(rmac), .RECIPIENT_MESSAGE(rmsg),
    .START_IP_TXN(start), .READY_FOR_SEND(ready_for_send),
    .MAC_DATA_VALID(mac_valid), .MAC_DATA_READY(mac_ready), .MAC_DATA_LAST(mac_last),
    .GRANT_ID(grant), .TX_BUSY(busy), .TX_DONE(done), .TX_ERROR(err),
    .TX_COUNT0(cnt0), .TX_COUNT1(cnt1)
  );

  ip_tx_scheduler #(.TIMEOUT_CYCLES(WD_T)) dut_wd (
    .aclk(aclk), .areset(areset), .REQ_VALID(req_valid),
    .REQ0_IP_ADDRESS(req_ip[0]), .REQ1_IP_ADDRESS(req_ip[1]),
    .REQ0_MAC_ADDRESS(req_mac[0]), .REQ1_MAC_ADDRESS(req_mac[1]),
    .REQ0_MESSAGE(req_msg[0]), .REQ1_MESSAGE(req_msg[1]),
    .REQ_ACCEPT(wd_accept), .RECIPIENT_IP_ADDRESS(wd_rip),
    .RECIPIENT_MAC_ADDRESS(wd_rmac), .RECIPIENT_MESSAGE(wd_rmsg),
    .START_IP_TXN(wd_start), .READY_FOR_SEND(ready_for_send),
    .MAC_DATA_VALID(mac_valid), .MAC_DATA_READY(mac_ready), .MAC_DATA_LAST(mac_last),
    .GRANT_ID(wd_grant), .TX_BUSY(wd_busy), .TX_DONE(wd_done), .TX_ERROR(wd_err),
    .TX_COUNT0(wd_cnt0), .TX_COUNT1(wd_cnt1)
  );

  // Arbitration rule: a lone request wins; a tie goes to the one not served last.
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    return v[1] ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic new_fields(input int r);
    req_ip[r]  = $urandom;
    req_mac[r] = {16'($urandom), 32'($urandom)};
    req_msg[r] = 10'($urandom);
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    req_valid = 2'b00;
    ready_for_send = 1'b0;
    {mac_valid, mac_ready, mac_last} = 3'b000;
    tick();
    tick();
    areset = 1'b0;
    exp_last = 1;
    exp_grant = 1'b0;
    exp_ip = '0;
    exp_mac = '0;
    exp_msg = '0;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    wd_exp_cnt0 = '0;
  endtask

  // Present a request in an idle cycle and check the grant one cycle later.
  task automatic issue(input logic [1:0] valid, input bit keep, input string tag);
    int         w;
    logic [1:0] e_acc;
    req_valid = valid;
    w = pick(valid, exp_last);
    tick();
    exp_last  = w;
    exp_grant = 1'(w);
    exp_ip    = req_ip[w];
    exp_mac   = req_mac[w];
    exp_msg   = req_msg[w];
    e_acc     = (w == 1) ? 2'b10 : 2'b01;
    n_checks++;
    if (accept !== e_acc) begin
      n_fail++; $display("FAIL %s accept: got %b want %b", tag, accept, e_acc);
    end
    n_checks++;
    if (grant !== exp_grant) begin
      n_fail++; $display("FAIL %s grant_id: got %b want %b", tag, grant, exp_grant);
    end
    n_checks++;
    if ({rip, rmac, rmsg} !== {exp_ip, exp_mac, exp_msg}) begin
      n_fail++; $display("FAIL %s recipient: got %h/%h/%h want %h/%h/%h",
                         tag, rip, rmac, rmsg, exp_ip, exp_mac, exp_msg);
    end
    n_checks++;
    if ({start, busy, done, err} !== 4'b1100) begin
      n_fail++; $display("FAIL %s launch flags start/busy/done/err: got %b want 1100",
                         tag, {start, busy, done, err});
    end
    // Requester reaction to its accept: re-request with new fields, or withdraw.
    if (keep) new_fields(w);
    else      req_valid[w] = 1'b0;
  endtask

  // Hold off the launch, run some non-final beats, then complete.
  task automatic launch_and_complete(input int ready_delay, input int beats, input string tag);
    logic [2:0] beat;
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      n_checks++;
      if ({start, busy, accept} !== 4'b1100 || {rip, rmac, rmsg} !== {exp_ip, exp_mac, exp_msg}) begin
        n_fail++; $display("FAIL %s launch_hold cyc %0d: got start/busy/accept %b ip %h want 1100 ip %h",
                           tag, i, {start, busy, accept}, rip, exp_ip);
      end
    end
    ready_for_send = 1'b1;
    tick();
    ready_for_send = 1'b0;
    n_checks++;
    if ({start, busy, accept} !== 4'b0100) begin
      n_fail++; $display("FAIL %s start_drop: got start/busy/accept %b want 0100",
                         tag, {start, busy, accept});
    end
    for (int i = 0; i < beats; i++) begin
      beat = 3'($urandom_range(0, 6));
      {mac_valid, mac_ready, mac_last} = beat;
      tick();
      n_checks++;
      if ({done, busy} !== 2'b01 || {rip, rmac, rmsg} !== {exp_ip, exp_mac, exp_msg}) begin
        n_fail++; $display("FAIL %s wait_beat %0d: got done/busy %b msg %h want 01 msg %h",
                           tag, i, {done, busy}, rmsg, exp_msg);
      end
    end
    {mac_valid, mac_ready, mac_last} = 3'b111;
    tick();
    {mac_valid, mac_ready, mac_last} = 3'b000;
    exp_cnt[exp_grant] = exp_cnt[exp_grant] + 16'd1;
    n_checks++;
    if ({done, err, busy} !== 3'b100) begin
      n_fail++; $display("FAIL %s complete done/err/busy: got %b want 100", tag, {done, err, busy});
    end
    n_checks++;
    if ({cnt0, cnt1} !== {exp_cnt[0], exp_cnt[1]}) begin
      n_fail++; $display("FAIL %s counts: got %h/%h want %h/%h", tag, cnt0, cnt1, exp_cnt[0], exp_cnt[1]);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({accept, start, busy, done, err, grant} !== 7'b0) begin
      n_fail++; $display("FAIL reset flags: got %b want 0000000", {accept, start, busy, done, err, grant});
    end
    n_checks++;
    if ({rip, rmac, rmsg} !== 90'b0) begin
      n_fail++; $display("FAIL reset recipient: got %h/%h/%h want 0", rip, rmac, rmsg);
    end
    n_checks++;
    if ({cnt0, cnt1} !== 32'b0) begin
      n_fail++; $display("FAIL reset counts: got %h/%h want 0/0", cnt0, cnt1);
    end
  endtask

  task automatic test_single();
    new_fields(1);
    req_ip[0]  = 32'h0A00_0002;
    req_mac[0] = 48'h1122_3344_5566;
    req_msg[0] = 10'h2A5;
    issue(2'b01, 1'b0, "single");
    launch_and_complete(3, 2, "single");
  endtask

  task automatic test_contention();
    apply_reset();
    new_fields(0);
    new_fields(1);
    for (int t = 0; t < 4; t++) begin
      issue(2'b11, 1'b1, "contention");
      if (t == 3) req_valid = 2'b00;
      launch_and_complete($urandom_range(0, 4), $urandom_range(0, 4), "contention");
    end
  endtask

  task automatic test_backpressure();
    new_fields(0);
    issue(2'b01, 1'b0, "backpressure");
    launch_and_complete(20, 1, "backpressure");
  endtask

  task automatic test_wrap();
    // Preload requester 1's counter to the wrap point instead of 65535 packets.
    dut.cnt1_q = 16'hFFFF;
    exp_cnt[1] = 16'hFFFF;
    new_fields(1);
    issue(2'b10, 1'b0, "wrap");
    launch_and_complete(1, 1, "wrap");
  endtask

  task automatic wd_case(input bit last_in_abort, input string tag);
    req_valid = 2'b01;
    new_fields(0);
    tick();
    n_checks++;
    if ({wd_accept, wd_busy} !== 3'b011) begin
      n_fail++; $display("FAIL %s wd_grant accept/busy: got %b want 011", tag, {wd_accept, wd_busy});
    end
    req_valid = 2'b00;
    ready_for_send = 1'b1;
    for (int j = 1; j < WD_T; j++) begin
      tick();
      ready_for_send = 1'b0;
      n_checks++;
      if ({wd_err, wd_busy} !== 2'b01) begin
        n_fail++; $display("FAIL %s wd_early cyc %0d err/busy: got %b want 01", tag, j, {wd_err, wd_busy});
      end
    end
    if (last_in_abort) {mac_valid, mac_ready, mac_last} = 3'b111;
    tick();
    {mac_valid, mac_ready, mac_last} = 3'b000;
    if (last_in_abort) wd_exp_cnt0 = wd_exp_cnt0 + 16'd1;
    n_checks++;
    if ({wd_done, wd_err, wd_busy} !== (last_in_abort ? 3'b100 : 3'b010)) begin
      n_fail++; $display("FAIL %s wd_end done/err/busy: got %b want %b", tag,
                         {wd_done, wd_err, wd_busy}, last_in_abort ? 3'b100 : 3'b010);
    end
    n_checks++;
    if ({wd_cnt0, wd_cnt1} !== {wd_exp_cnt0, 16'h0}) begin
      n_fail++; $display("FAIL %s wd_counts: got %h/%h want %h/0000", tag, wd_cnt0, wd_cnt1, wd_exp_cnt0);
    end
    tick();
    n_checks++;
    if ({wd_done, wd_err, wd_busy} !== 3'b000) begin
      n_fail++; $display("FAIL %s wd_pulse_width: got %b want 000", tag, {wd_done, wd_err, wd_busy});
    end
  endtask

  task automatic test_watchdog();
    apply_reset();
    wd_case(1'b0, "wd_abort");
    wd_case(1'b1, "wd_last_in_abort");
  endtask

  task automatic test_mid_reset();
    apply_reset();
    new_fields(0);
    new_fields(1);
    issue(2'b01, 1'b0, "midrst");
    ready_for_send = 1'b1;
    tick();
    ready_for_send = 1'b0;
    tick();
    // Reset lands on a cycle that also carries a final beat.
    areset = 1'b1;
    {mac_valid, mac_ready, mac_last} = 3'b111;
    tick();
    areset = 1'b0;
    {mac_valid, mac_ready, mac_last} = 3'b000;
    exp_last = 1;
    n_checks++;
    if ({accept, start, busy, done, err, grant} !== 7'b0) begin
      n_fail++; $display("FAIL midrst flags: got %b want 0000000", {accept, start, busy, done, err, grant});
    end
    n_checks++;
    if ({rip, rmac, rmsg} !== 90'b0 || {cnt0, cnt1} !== 32'b0) begin
      n_fail++; $display("FAIL midrst data: got ip %h cnt %h/%h want 0", rip, cnt0, cnt1);
    end
    tick();
    n_checks++;
    if ({done, err, busy} !== 3'b000) begin
      n_fail++; $display("FAIL midrst late_pulse: got %b want 000", {done, err, busy});
    end
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    issue(2'b11, 1'b0, "midrst_tie");
    req_valid = 2'b00;
    launch_and_complete(1, 0, "midrst_tie");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    req_valid = 2'b00;
    ready_for_send = 1'b0;
    {mac_valid, mac_ready, mac_last} = 3'b000;
    new_fields(0);
    new_fields(1);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_watchdog();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_tx_scheduler.md
# ip_tx_scheduler

Two-requester round-robin scheduler that shares the single IP packet transmitter between the load-balancer response path (requester 0) and the inference result path (requester 1). It latches the winning request's destination and payload, launches one transmit transaction, holds the transmitter inputs stable until the final MAC beat is accepted, and recovers from a stalled transaction with a watchdog. It sits between the accelerator core and the packet transmitter.

## Interface
- IP_ADDR_WIDTH, 32, IPv4 address width
- MAC_ADDR_WIDTH, 48, Ethernet address width
- ACCEL_DATA_WIDTH, 10, payload message width
- TIMEOUT_CYCLES, 1024, maximum cycles from launch to final beat before abort (legal range 2..65535)

Ports:
- aclk  in  1  clock; one clock domain, all logic on the rising edge
- areset  in  1  reset, synchronous, active-high
- REQ_VALID  in  2  per-requester request; requester holds it and its fields stable until accepted
- REQ0_IP_ADDRESS / REQ1_IP_ADDRESS  in  IP_ADDR_WIDTH  destination IP
- REQ0_MAC_ADDRESS / REQ1_MAC_ADDRESS  in  MAC_ADDR_WIDTH  destination MAC
- REQ0_MESSAGE / REQ1_MESSAGE  in  ACCEL_DATA_WIDTH  payload
- REQ_ACCEPT  out  2  one-cycle pulse on the granted requester's bit
- RECIPIENT_IP_ADDRESS  out  IP_ADDR_WIDTH  latched destination IP to transmitter
- RECIPIENT_MAC_ADDRESS  out  MAC_ADDR_WIDTH  latched destination MAC
- RECIPIENT_MESSAGE  out  ACCEL_DATA_WIDTH  latched payload
- START_IP_TXN  out  1  launch request to transmitter
- READY_FOR_SEND  in  1  transmitter idle and MAC ready
- MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST  in  1 each  snooped transmitter/MAC handshake
- GRANT_ID  out  1  requester owning the current transaction
- TX_BUSY  out  1  high in LAUNCH or WAIT_LAST
- TX_DONE  out  1  one-cycle pulse on completion
- TX_ERROR  out  1  one-cycle pulse on watchdog abort
- TX_COUNT0 / TX_COUNT1  out  16 each  completed packets per requester

## Operation
- States: IDLE, LAUNCH, WAIT_LAST.
- IDLE: if any REQ_VALID bit set, choose the winner, latch its three fields into the RECIPIENT_* registers, set GRANT_ID, pulse REQ_ACCEPT[winner], go LAUNCH. READY_FOR_SEND is not required in IDLE.
- Arbitration: single valid wins. Both valid: winner = ~last_grant. last_grant updates to the winner on every grant; reset value 1, so requester 0 wins the first tie.
- LAUNCH: START_IP_TXN = 1. On a cycle with READY_FOR_SEND = 1, go WAIT_LAST next edge; START_IP_TXN falls with the state change.
- WAIT_LAST: completion = MAC_DATA_VALID & MAC_DATA_READY & MAC_DATA_LAST. On completion: pulse TX_DONE, increment TX_COUNT[GRANT_ID] (16-bit, wraps 0xFFFF→0x0000), go IDLE.
- Watchdog: 16-bit counter cleared on entry to LAUNCH, increments every cycle in LAUNCH/WAIT_LAST. In the cycle it equals TIMEOUT_CYCLES-1 without completion: pulse TX_ERROR, go IDLE, no count increment. Completion in that same cycle takes priority: TX_DONE, no TX_ERROR.
- RECIPIENT_* and GRANT_ID hold their values from capture until the next grant; they are not cleared on return to IDLE.
- REQ_VALID changes while in LAUNCH/WAIT_LAST are ignored. A request still valid on return to IDLE is arbitrated as a new request.

## Timing
- Reset: state IDLE, last_grant 1; REQ_ACCEPT 0, START_IP_TXN 0, RECIPIENT_* 0, GRANT_ID 0, TX_BUSY 0, TX_DONE 0, TX_ERROR 0, TX_COUNT0/1 0, watchdog 0. Reset mid-transaction abandons it with no DONE/ERROR pulse.
- All outputs are registered.
- REQ_VALID high in IDLE cycle n → REQ_ACCEPT, START_IP_TXN, TX_BUSY and new RECIPIENT_* all visible in cycle n+1.
- READY_FOR_SEND high in LAUNCH cycle m → START_IP_TXN low and state WAIT_LAST in m+1.
- Completion beat in cycle k → TX_DONE high and TX_BUSY low in k+1. A new grant is possible at the earliest in k+1, so its REQ_ACCEPT appears in k+2. The minimum gap between back-to-back launches is one idle cycle.

## Test plan
- Single request: REQ_VALID=01, IP 0x0A000002, MAC 0x112233445566, msg 0x2A5. Expect REQ_ACCEPT=01 one cycle later, RECIPIENT_* match, START held until READY_FOR_SEND, TX_DONE after LAST beat, TX_COUNT0=1.
- Contention: REQ_VALID=11 held for four transactions. Expect grants 0,1,0,1, each REQ_ACCEPT exactly one cycle wide, RECIPIENT_* stable throughout each transaction.
- Backpressure: READY_FOR_SEND low for 20 cycles in LAUNCH. START_IP_TXN must stay high for all 20 cycles, then drop one cycle after READY_FOR_SEND rises.
- Watchdog: TIMEOUT_CYCLES=16, never send LAST. Expect TX_ERROR pulse 16 cycles after LAUNCH entry, state IDLE, counters unchanged. Repeat with LAST arriving in the abort cycle: expect TX_DONE only.
- Counter wrap: preload traffic to 65535 completions on requester 1. The next completion gives TX_COUNT1=0, with TX_COUNT0 untouched.
- Mid-operation reset: assert areset for one cycle in WAIT_LAST. Next cycle all outputs at reset values, no DONE/ERROR pulse, and the first tie afterward grants requester 0.
